// File: rtl/sort_if.sv
// Data bundle for the five-word sorter: five unsorted words in, five sorted words out.
// The master drives the inputs and observes the outputs; the sorter is the slave.
interface sort_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] in4;
    logic [WIDTH-1:0] in5;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out4;
    logic [WIDTH-1:0] out5;

    modport master (
        output in1, in2, in3, in4, in5,
        input  out1, out2, out3, out4, out5
    );

    modport slave (
        input  in1, in2, in3, in4, in5,
        output out1, out2, out3, out4, out5
    );
endinterface

// File: rtl/sort.sv
// Fully pipelined five-word unsigned sorter: input register, odd-even transposition
// network, output register. One set per cycle, results two edges after capture.
module sort #(
    parameter int WIDTH = 16
) (
    input logic   clk,
    input logic   rst,
    sort_if.slave bus
);
    logic [WIDTH-1:0] r   [5];
    logic [WIDTH-1:0] net [5];
    logic [WIDTH-1:0] q   [5];

    // Five alternating passes of compare-exchange; min lands on the lower index.
    always_comb begin
        // NOTE: assign the whole result first so no path through the loop leaves it unassigned (no latch).
        net = r;
        for (int p = 0; p < 5; p++) begin
            for (int i = p % 2; i < 4; i += 2) begin
                if (net[i] > net[i+1]) begin
                    {net[i], net[i+1]} = {net[i+1], net[i]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these few pipeline registers are reset so the outputs read a defined 0; bulk storage arrays would not be.
            for (int i = 0; i < 5; i++) begin
                r[i] <= '0;
                q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r[0] <= bus.in1;
            r[1] <= bus.in2;
            r[2] <= bus.in3;
            r[3] <= bus.in4;
            r[4] <= bus.in5;
            q    <= net;
        end
    end

    assign bus.out1 = q[0];
    assign bus.out2 = q[1];
    assign bus.out3 = q[2];
    assign bus.out4 = q[3];
    assign bus.out5 = q[4];
endmodule

// File: tb/tb_sort.sv
// Directed and random checks of the five-word sorter, two-edge latency, with
// asynchronous reset both at start-up and in the middle of a stream.
module tb_sort;
    localparam int WIDTH = 16;
    typedef logic [5*WIDTH-1:0] set_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    set_t  exp_q [$];
    string tag_q [$];
    set_t  obs;

    sort_if #(.WIDTH(WIDTH)) bus ();
    sort #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign obs = {bus.out1, bus.out2, bus.out3, bus.out4, bus.out5};

    task automatic check(input string tag, input set_t got, input set_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input set_t s);
        {bus.in1, bus.in2, bus.in3, bus.in4, bus.in5} = s;
    endtask

    // Insertion sort over the five words; first word of the packed set is the smallest.
    function automatic set_t model(input set_t s);
        logic [WIDTH-1:0] w [5];
        logic [WIDTH-1:0] t;
        int j;
        for (int i = 0; i < 5; i++) w[i] = s[(4-i)*WIDTH +: WIDTH];
        for (int i = 1; i < 5; i++) begin
            t = w[i];
            j = i - 1;
            while (j >= 0 && w[j] > t) begin
                w[j+1] = w[j];
                j--;
            end
            w[j+1] = t;
        end
        return {w[0], w[1], w[2], w[3], w[4]};
    endfunction

    // One pipeline step: check the set issued two negedges ago, then issue a new one.
    task automatic cycle(input string tag, input set_t s, input set_t exp);
        @(negedge clk);
        if (exp_q.size() == 2) check(tag_q.pop_front(), obs, exp_q.pop_front());
        drive(s);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic seed_zero(input string tag);
        exp_q.delete();
        tag_q.delete();
        repeat (2) begin
            exp_q.push_back('0);
            tag_q.push_back(tag);
        end
    endtask

    initial begin
        set_t s;

        drive('0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_hold", obs, '0);
        rst = 1'b0;
        seed_zero("post_release");

        cycle("known_set", {16'd5, 16'd1, 16'd4, 16'd2, 16'd3},
                           {16'd1, 16'd2, 16'd3, 16'd4, 16'd5});
        cycle("reverse",   {16'hFFFF, 16'h8000, 16'h00FF, 16'h0010, 16'h0000},
                           {16'h0000, 16'h0010, 16'h00FF, 16'h8000, 16'hFFFF});
        cycle("dup_ext",   {16'd7, 16'd7, 16'd0, 16'hFFFF, 16'd7},
                           {16'd0, 16'd7, 16'd7, 16'd7, 16'hFFFF});
        cycle("all_equal", {5{16'hABCD}}, {5{16'hABCD}});
        cycle("b2b_1",     {16'd1, 16'd2, 16'd3, 16'd4, 16'd5},
                           {16'd1, 16'd2, 16'd3, 16'd4, 16'd5});
        cycle("b2b_2",     {16'd50, 16'd40, 16'd30, 16'd20, 16'd10},
                           {16'd10, 16'd20, 16'd30, 16'd40, 16'd50});
        cycle("b2b_3",     {16'd9, 16'd9, 16'd9, 16'd9, 16'd1},
                           {16'd1, 16'd9, 16'd9, 16'd9, 16'd9});

        for (int n = 0; n < 10000; n++) begin
            for (int k = 0; k < 5; k++) s[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            cycle("random", s, model(s));
        end

        // Asynchronous clear between edges while a known set sits on the outputs.
        repeat (3) cycle("pre_reset", {5{16'd3}}, {5{16'd3}});
        #2;
        check("outputs_before_rst", obs, {5{16'd3}});
        rst = 1'b1;
        #1;
        check("async_clear", obs, '0);
        exp_q.delete();
        tag_q.delete();
        @(negedge clk);
        check("rst_over_edge", obs, '0);
        drive('0);
        rst = 1'b0;
        seed_zero("release_zero");

        // Two sets in flight, then a reset pulse that must discard both.
        cycle("flight_seed", {16'd8, 16'd6, 16'd7, 16'd5, 16'd3},
                             {16'd3, 16'd5, 16'd6, 16'd7, 16'd8});
        cycle("flight_seed", {16'd2, 16'd2, 16'd1, 16'd1, 16'd0},
                             {16'd0, 16'd1, 16'd1, 16'd2, 16'd2});
        @(negedge clk);
        check("inflight_a", obs, exp_q.pop_front());
        drive('0);
        #2 rst = 1'b1;
        #1;
        check("mid_stream_clear", obs, '0);
        #1 rst = 1'b0;
        seed_zero("after_pulse");
        cycle("after_pulse", {16'd4, 16'd0, 16'd9, 16'd1, 16'd1},
                             {16'd0, 16'd1, 16'd1, 16'd4, 16'd9});
        cycle("drain", '0, '0);
        cycle("drain", '0, '0);
        cycle("drain", '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
